seg_scan_capture: RTL and testbench
===================================

Name: seg_scan_capture

Overview:
- Receive side of the 7-segment display interface: samples a multiplexed, active-low segment/digit-select bus and reconstructs BCD8421 digits per display position.
- Each complete scan (every digit captured once) is presented as one frame through a valid/ready handshake.
- Used by the on-board display checker and self-test logic downstream of the display driver path.

Parameters:
- NDIG, 4, number of multiplexed digit positions.
- STABLE_CYC, 8, consecutive unchanged cycles required before a digit is sampled (1..2^CNT_W-1).
- CNT_W, 4, width of the stability counter.

Ports:
- clk_i  input  1  system clock.
- rst_n_i  input  1  reset.
- seg_i  input  7  segments {a,b,c,d,e,f,g}, low = lit; asynchronous to clk_i.
- dig_sel_i  input  NDIG  digit selects, low = selected; asynchronous to clk_i.
- bcd_o  output  4*NDIG  frame digits; digit k at bits [4k+3:4k].
- err_o  output  NDIG  per-digit illegal-pattern flag for the held frame.
- frame_valid_o  output  1  frame available.
- frame_ready_i  input  1  consumer accepts the frame.
- ovf_o  output  1  one-cycle pulse when a completed frame is dropped.

Interface decision: one clock; reset is asynchronous and active-low (clk_i, rst_n_i).

Behaviour:
- Reset values: bcd_o=0, err_o=0, frame_valid_o=0, ovf_o=0. Synchronisers, counter, armed flag, capture mask and staging registers are also cleared. Reset asserted mid-operation aborts the scan in progress and drops any held frame.
- Input path: seg_i and dig_sel_i each pass through a 2-flop synchroniser. All logic below uses the synchronised values (s_seg, s_sel).
- Stability FSM:
  - IDLE: entered on any change of {s_seg, s_sel} versus the previous cycle, or when s_sel is not exactly one-low (all high, or several low). Counter = 0, armed = 1.
  - COUNT: {s_seg, s_sel} unchanged and s_sel one-low. Counter increments, saturating at STABLE_CYC.
  - CAPTURE: single cycle in which the counter reaches STABLE_CYC while armed = 1. The selected digit k is decoded and written to staging, mask[k] is set, and armed is cleared.
  - One capture per stable period. A re-capture of an already captured digit overwrites its staging entry.
- Pattern decode (active low, {a..g}):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100.
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100.
  - Blank 1111111 -> code 4'hA, err = 0.
  - Any other pattern -> code 4'hF, err = 1.
- Latency: 2 synchroniser cycles + STABLE_CYC cycles from a pin change to the capture cycle. frame_valid_o rises the cycle after the capture that completes the mask.
- Frame completion (mask all ones after a capture):
  - Staging is copied to bcd_o/err_o and frame_valid_o is set, if frame_valid_o=0 or frame_ready_i=1 in that cycle.
  - Otherwise the held frame is preserved, the new frame is dropped, and ovf_o pulses for 1 cycle.
  - The mask clears in every completion case.
- Handshake:
  - Transfer occurs when frame_valid_o & frame_ready_i.
  - bcd_o, err_o and frame_valid_o are stable while valid and not ready.
  - Transfer without a simultaneous completion clears frame_valid_o next cycle.
  - Transfer coinciding with a completion loads the new frame, and frame_valid_o stays 1.
  - frame_ready_i has no effect while frame_valid_o=0.

Decomposition:
- Package seg_scan_pkg holds:
  - the ten digit pattern constants;
  - PAT_BLANK = 7'b1111111;
  - CODE_BLANK = 4'hA;
  - CODE_ERR = 4'hF.
- Sub-module seg_pattern_decode: combinational, 7-bit pattern in, 4-bit code and err flag out. It is instantiated once, on s_seg.
- The synchronisers, stability FSM, mask/staging and handshake stay in the top module.

Test Plan:
- Reset: hold rst_n_i=0 mid-scan with traffic present -> all outputs 0; release -> no frame_valid_o until a full new scan.
- Clean scan, NDIG=4: drive digits 3,0,1,9 with 20 cycles per select -> frame_valid_o=1 with bcd_o=16'h9103 and err_o=0. frame_valid_o rises exactly 1 cycle after the 4th capture, 2+8 cycles after that digit's pins settle.
- Glitch rejection: change seg_i 5 cycles into a select period, then hold the correct pattern -> exactly one capture, timed from the last change. A 3-cycle two-low dig_sel_i produces no capture.
- Blank and illegal: digit1 = 1111111, digit2 = 1111110 -> bcd_o nibbles 1 and 2 are 4'hA and 4'hF; err_o = 4'b0100.
- Back-pressure: frame_ready_i=0 across two full scans -> first frame held unchanged, ovf_o pulses once at the second completion. frame_ready_i=1 on the cycle the third scan completes -> third frame loaded, frame_valid_o stays 1.
- Handshake: frame_ready_i=1 on the cycle after frame_valid_o rises -> frame_valid_o=0 next cycle, and no ovf_o.

Source files
------------

// File: rtl/seg_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seg_scan_pkg                                              |
// | Brief    : Segment patterns and codes for the scan capture receiver. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package seg_scan_pkg;
   // Active-low patterns, bit order {a,b,c,d,e,f,g}
   localparam logic [6:0] PAT_0     = 7'b0000001;
   localparam logic [6:0] PAT_1     = 7'b1001111;
   localparam logic [6:0] PAT_2     = 7'b0010010;
   localparam logic [6:0] PAT_3     = 7'b0000110;
   localparam logic [6:0] PAT_4     = 7'b1001100;
   localparam logic [6:0] PAT_5     = 7'b0100100;
   localparam logic [6:0] PAT_6     = 7'b0100000;
   localparam logic [6:0] PAT_7     = 7'b0001111;
   localparam logic [6:0] PAT_8     = 7'b0000000;
   localparam logic [6:0] PAT_9     = 7'b0000100;
   localparam logic [6:0] PAT_BLANK = 7'b1111111;
   localparam logic [3:0] CODE_BLANK = 4'hA;
   localparam logic [3:0] CODE_ERR   = 4'hF;
endpackage
`default_nettype wire

// File: rtl/seg_pattern_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seg_pattern_decode                                        |
// | Brief    : Active-low 7-segment pattern to BCD code and error flag.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module seg_pattern_decode
   import seg_scan_pkg::*;
(
   input  logic [6:0] i_pat,
   output logic [3:0] o_code,
   output logic       o_err
);
   always_comb begin
      o_code = CODE_ERR;
      o_err  = 1'b1;
      case (i_pat)
         PAT_0:     begin o_code = 4'd0;       o_err = 1'b0; end
         PAT_1:     begin o_code = 4'd1;       o_err = 1'b0; end
         PAT_2:     begin o_code = 4'd2;       o_err = 1'b0; end
         PAT_3:     begin o_code = 4'd3;       o_err = 1'b0; end
         PAT_4:     begin o_code = 4'd4;       o_err = 1'b0; end
         PAT_5:     begin o_code = 4'd5;       o_err = 1'b0; end
         PAT_6:     begin o_code = 4'd6;       o_err = 1'b0; end
         PAT_7:     begin o_code = 4'd7;       o_err = 1'b0; end
         PAT_8:     begin o_code = 4'd8;       o_err = 1'b0; end
         PAT_9:     begin o_code = 4'd9;       o_err = 1'b0; end
         PAT_BLANK: begin o_code = CODE_BLANK; o_err = 1'b0; end
         default:   ;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/seg_scan_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seg_scan_capture                                          |
// | Brief    : Samples a multiplexed segment bus and emits BCD frames.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module seg_scan_capture
   import seg_scan_pkg::*;
#(
   parameter int NDIG       = 4,
   parameter int STABLE_CYC = 8,
   parameter int CNT_W      = 4
)(
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [6:0]        seg_i,
   input  logic [NDIG-1:0]   dig_sel_i,
   output logic [4*NDIG-1:0] bcd_o,
   output logic [NDIG-1:0]   err_o,
   output logic              frame_valid_o,
   input  logic              frame_ready_i,
   output logic              ovf_o
);
   localparam logic [1:0]       c_st_idle    = 2'd0;
   localparam logic [1:0]       c_st_count   = 2'd1;
   localparam logic [1:0]       c_st_capture = 2'd2;
   localparam logic [CNT_W-1:0] c_stable     = CNT_W'(STABLE_CYC);
   localparam logic [CNT_W-1:0] c_stable_m1  = CNT_W'(STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
   localparam logic [NDIG-1:0]  c_sel_one    = NDIG'(1);
   localparam logic [NDIG-1:0]  c_mask_full  = '1;

   logic [6:0]        r_seg_m, r_seg_s, r_seg_prev;
   logic [NDIG-1:0]   r_sel_m, r_sel_s, r_sel_prev;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_armed;
   logic [NDIG-1:0]   r_mask;
   logic [4*NDIG-1:0] r_stage_bcd;
   logic [NDIG-1:0]   r_stage_err;
   logic [4*NDIG-1:0] r_bcd;
   logic [NDIG-1:0]   r_err;
   logic              r_valid;
   logic              r_ovf;

   logic [1:0]        w_state;
   logic [NDIG-1:0]   w_hit;
   logic              w_one_low;
   logic [3:0]        w_code;
   logic              w_err;
   logic [NDIG-1:0]   w_mask;
   logic [4*NDIG-1:0] w_stage_bcd;
   logic [NDIG-1:0]   w_stage_err;
   logic              w_complete;

   seg_pattern_decode u_decode (
      .i_pat  (r_seg_s),
      .o_code (w_code),
      .o_err  (w_err)
   );

   // Selects are active low, so the inverted bus is the selected-digit one-hot
   assign w_hit     = ~r_sel_s;
   assign w_one_low = (w_hit != '0) && ((w_hit & (w_hit - c_sel_one)) == '0);

   always_comb begin
      w_state = c_st_count;
      if (({r_seg_s, r_sel_s} != {r_seg_prev, r_sel_prev}) || !w_one_low)
         w_state = c_st_idle;
      else if (r_armed && (r_cnt == c_stable_m1))
         w_state = c_st_capture;
   end

   always_comb begin
      w_mask      = r_mask;
      w_stage_bcd = r_stage_bcd;
      w_stage_err = r_stage_err;
      if (w_state == c_st_capture) begin
         w_mask = r_mask | w_hit;
         for (int k = 0; k < NDIG; k++) begin
            if (w_hit[k]) begin
               w_stage_bcd[4*k +: 4] = w_code;
               w_stage_err[k]        = w_err;
            end
         end
      end
   end

   assign w_complete = (w_state == c_st_capture) && (w_mask == c_mask_full);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_seg_m     <= '0;
         r_seg_s     <= '0;
         r_seg_prev  <= '0;
         r_sel_m     <= '0;
         r_sel_s     <= '0;
         r_sel_prev  <= '0;
         r_cnt       <= '0;
         r_armed     <= 1'b0;
         r_mask      <= '0;
         r_stage_bcd <= '0;
         r_stage_err <= '0;
         r_bcd       <= '0;
         r_err       <= '0;
         r_valid     <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_seg_m    <= seg_i;
         r_seg_s    <= r_seg_m;
         r_seg_prev <= r_seg_s;
         r_sel_m    <= dig_sel_i;
         r_sel_s    <= r_sel_m;
         r_sel_prev <= r_sel_s;

         case (w_state)
            c_st_count: begin
               if (r_cnt < c_stable)
                  r_cnt <= r_cnt + c_cnt_one;
            end
            c_st_capture: begin
               r_cnt   <= c_stable;
               r_armed <= 1'b0;
            end
            default: begin
               r_cnt   <= '0;
               r_armed <= 1'b1;
            end
         endcase

         r_stage_bcd <= w_stage_bcd;
         r_stage_err <= w_stage_err;
         r_mask      <= w_complete ? '0 : w_mask;

         // A completed frame wins over a plain transfer; it drops only when blocked
         r_ovf <= 1'b0;
         if (w_complete) begin
            if (!r_valid || frame_ready_i) begin
               r_bcd   <= w_stage_bcd;
               r_err   <= w_stage_err;
               r_valid <= 1'b1;
            end else begin
               r_ovf <= 1'b1;
            end
         end else if (r_valid && frame_ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign bcd_o         = r_bcd;
   assign err_o         = r_err;
   assign frame_valid_o = r_valid;
   assign ovf_o         = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_seg_scan_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_seg_scan_capture                                       |
// | Brief    : Scoreboard bench for seg_scan_capture with a frame model. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_seg_scan_capture;
   localparam int NDIG = 4;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic [6:0]  seg_i = 7'h7F;
   logic [3:0]  dig_sel_i = 4'hF;
   logic [15:0] bcd_o;
   logic [3:0]  err_o;
   logic        frame_valid_o;
   logic        frame_ready_i = 1'b0;
   logic        ovf_o;

   seg_scan_capture #(.NDIG(NDIG), .STABLE_CYC(8), .CNT_W(4)) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .seg_i         (seg_i),
      .dig_sel_i     (dig_sel_i),
      .bcd_o         (bcd_o),
      .err_o         (err_o),
      .frame_valid_o (frame_valid_o),
      .frame_ready_i (frame_ready_i),
      .ovf_o         (ovf_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0, last_set_cyc = 0, rise_cyc = 0;
   int ovf_seen = 0, ovf_exp = 0, frames_pushed = 0;
   logic prev_v = 1'b0;
   bit drop_next = 1'b0;
   logic [15:0] exp_bcd_q[$];
   logic [3:0]  exp_err_q[$];
   logic [3:0]  m_mask = 4'h0;
   logic [15:0] m_bcd = 16'h0;
   logic [3:0]  m_err = 4'h0;
   logic [6:0]  last_seg = 7'h7F;
   logic [3:0]  last_sel = 4'hF;
   logic [6:0]  pat_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100};

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void ref_decode(input logic [6:0] p, output logic [3:0] c, output logic e);
      c = 4'hF;
      e = 1'b1;
      if (p == 7'b1111111) begin c = 4'hA; e = 1'b0; end
      for (int d = 0; d < 10; d++)
         if (pat_tab[d] == p) begin c = d[3:0]; e = 1'b0; end
   endfunction

   // One select period: value held for 'hold' clocks; a long one-low period is one capture
   task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input int hold);
      logic [3:0] c;
      logic       e;
      @(posedge clk_i); #1;
      seg_i = seg;
      dig_sel_i = sel;
      last_seg = seg;
      last_sel = sel;
      last_set_cyc = cyc;
      if (hold >= 12 && $countones(~sel) == 1) begin
         ref_decode(seg, c, e);
         for (int k = 0; k < NDIG; k++) begin
            if (!sel[k]) begin
               m_bcd[4*k +: 4] = c;
               m_err[k] = e;
               m_mask[k] = 1'b1;
            end
         end
         if (m_mask == 4'hF) begin
            m_mask = 4'h0;
            if (drop_next) begin
               ovf_exp++;
               drop_next = 1'b0;
            end else begin
               exp_bcd_q.push_back(m_bcd);
               exp_err_q.push_back(m_err);
               frames_pushed++;
            end
         end
      end
      repeat (hold - 1) @(posedge clk_i);
   endtask

   function automatic logic [3:0] sel_of(input int k);
      logic [3:0] s;
      s = 4'b0001 << k;
      return ~s;
   endfunction

   task automatic scan(input int d0, input int d1, input int d2, input int d3, input int hold);
      drive(sel_of(0), pat_tab[d0], hold);
      drive(sel_of(1), pat_tab[d1], hold);
      drive(sel_of(2), pat_tab[d2], hold);
      drive(sel_of(3), pat_tab[d3], hold);
   endtask

   // Monitor: pops the scoreboard on every transfer
   initial begin
      forever begin
         @(negedge clk_i);
         if (rst_n_i) begin
            if (ovf_o) ovf_seen++;
            if (frame_valid_o && !prev_v) rise_cyc = cyc;
            if (frame_valid_o && frame_ready_i) begin
               check("frame_expected", {31'd0, exp_bcd_q.size() != 0}, 32'd1);
               if (exp_bcd_q.size() != 0) begin
                  check("frame_bcd", {16'd0, bcd_o}, {16'd0, exp_bcd_q.pop_front()});
                  check("frame_err", {28'd0, err_o}, {28'd0, exp_err_q.pop_front()});
               end
            end
         end
         prev_v = frame_valid_o;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rv;
      logic [3:0]  sel;
      logic [6:0]  seg;
      int          hold, iter, ovf_before;
      bit          got;

      repeat (4) @(posedge clk_i);
      @(negedge clk_i);
      check("reset_bcd", {16'd0, bcd_o}, 32'd0);
      check("reset_err", {28'd0, err_o}, 32'd0);
      check("reset_valid", {31'd0, frame_valid_o}, 32'd0);
      check("reset_ovf", {31'd0, ovf_o}, 32'd0);
      @(posedge clk_i); #1 rst_n_i = 1'b1;

      // Clean scan
      frame_ready_i = 1'b1;
      scan(3, 0, 1, 9, 20);
      check("clean_bcd", {16'd0, bcd_o}, 32'h9103);
      check("clean_err", {28'd0, err_o}, 32'd0);
      check("clean_latency", rise_cyc - last_set_cyc, 32'd11);

      // Glitch and two-low rejection
      drive(sel_of(0), pat_tab[7], 20);
      drive(sel_of(1), pat_tab[2], 20);
      drive(sel_of(2), pat_tab[5], 20);
      drive(4'b0110, pat_tab[8], 3);
      drive(4'b0110, pat_tab[1], 15);
      drive(sel_of(3), pat_tab[3], 5);
      drive(sel_of(3), pat_tab[8], 20);
      check("glitch_latency", rise_cyc - last_set_cyc, 32'd11);
      check("glitch_bcd", {16'd0, bcd_o}, 32'h8527);

      // Blank and illegal
      drive(sel_of(0), pat_tab[4], 20);
      drive(sel_of(1), 7'b1111111, 20);
      drive(sel_of(2), 7'b1111110, 20);
      drive(sel_of(3), pat_tab[6], 20);
      check("blank_bcd", {16'd0, bcd_o}, 32'h6FA4);
      check("blank_err", {28'd0, err_o}, 32'h4);

      // Back-pressure across two scans, ready raised on the third completion
      frame_ready_i = 1'b0;
      ovf_before = ovf_seen;
      scan(1, 2, 3, 4, 20);
      drop_next = 1'b1;
      scan(5, 6, 7, 8, 20);
      check("bp_held_bcd", {16'd0, bcd_o}, 32'h4321);
      check("bp_held_valid", {31'd0, frame_valid_o}, 32'd1);
      check("bp_ovf_once", ovf_seen - ovf_before, 32'd1);
      drive(sel_of(0), pat_tab[9], 20);
      drive(sel_of(1), pat_tab[0], 20);
      drive(sel_of(2), pat_tab[2], 20);
      fork
         drive(sel_of(3), pat_tab[4], 20);
         begin
            @(posedge clk_i);
            repeat (10) @(posedge clk_i);
            #1 frame_ready_i = 1'b1;
            @(posedge clk_i);
            @(negedge clk_i);
            check("bp_third_valid", {31'd0, frame_valid_o}, 32'd1);
            check("bp_third_bcd", {16'd0, bcd_o}, 32'h4209);
         end
      join
      check("bp_no_extra_ovf", ovf_seen - ovf_before, 32'd1);

      // Handshake: ready one cycle after valid rises
      frame_ready_i = 1'b0;
      ovf_before = ovf_seen;
      fork
         scan(2, 4, 6, 8, 20);
         begin
            got = 1'b0;
            for (int i = 0; i < 300 && !got; i++) begin
               @(negedge clk_i);
               if (frame_valid_o) got = 1'b1;
            end
            check("hs_valid_seen", {31'd0, got}, 32'd1);
            @(posedge clk_i); #1 frame_ready_i = 1'b1;
            @(negedge clk_i);
            @(negedge clk_i);
            check("hs_valid_cleared", {31'd0, frame_valid_o}, 32'd0);
         end
      join
      check("hs_no_ovf", ovf_seen - ovf_before, 32'd0);

      // Reset mid-scan with a held frame and traffic present
      frame_ready_i = 1'b0;
      scan(1, 1, 1, 1, 20);
      drive(sel_of(0), pat_tab[5], 20);
      drive(sel_of(1), pat_tab[6], 20);
      drive(sel_of(2), pat_tab[7], 5);
      #1 rst_n_i = 1'b0;
      exp_bcd_q.delete();
      exp_err_q.delete();
      m_mask = 4'h0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk_i); #1;
         rv = $urandom();
         seg_i = rv[6:0];
         dig_sel_i = rv[10:7];
      end
      @(negedge clk_i);
      check("midrst_bcd", {16'd0, bcd_o}, 32'd0);
      check("midrst_err", {28'd0, err_o}, 32'd0);
      check("midrst_valid", {31'd0, frame_valid_o}, 32'd0);
      check("midrst_ovf", {31'd0, ovf_o}, 32'd0);
      @(posedge clk_i); #1 rst_n_i = 1'b1;
      drive(sel_of(0), pat_tab[3], 20);
      drive(sel_of(1), pat_tab[3], 20);
      drive(sel_of(2), pat_tab[3], 20);
      check("postrst_no_valid", {31'd0, frame_valid_o}, 32'd0);
      frame_ready_i = 1'b1;
      drive(sel_of(3), pat_tab[3], 20);

      // Randomized periods, consumer always ready
      iter = 0;
      ovf_before = frames_pushed;
      while (frames_pushed - ovf_before < 6 && iter < 400) begin
         iter++;
         rv = $urandom();
         if (rv[3:0] == 4'd0)      sel = 4'hF;
         else if (rv[3:0] == 4'd1) sel = 4'b1010;
         else                      sel = sel_of(int'(rv[5:4]));
         rv = $urandom();
         if (rv[3:0] < 4'd11)       seg = pat_tab[rv[3:0] % 10];
         else if (rv[3:0] == 4'd11) seg = 7'b1111111;
         else                       seg = rv[14:8];
         if (sel == last_sel && seg == last_seg) seg = seg ^ 7'h01;
         hold = ($urandom_range(0, 9) < 7) ? $urandom_range(12, 20) : $urandom_range(2, 6);
         drive(sel, seg, hold);
      end
      repeat (30) @(posedge clk_i);
      check("queue_drained", exp_bcd_q.size(), 32'd0);
      check("ovf_total", ovf_seen, ovf_exp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
